// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, imem request port, prefetch FIFO, redirect
//
// Purpose: owns the fetch PC and issues in-order word requests to instruction memory.
// Returned words go into a small prefetch FIFO, and the FIFO head is presented to IF/ID.
// A flush redirects fetch to redirect_pc and discards every response still in flight.
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-low reset
//   stall                       hold the IF/ID head (no pop)
//   flush, redirect_pc          redirect fetch; has priority over stall
//   imem_req_valid/ready, imem_addr   request port (addr held while valid & !ready)
//   imem_rsp_valid, imem_rsp_data     in-order responses, always accepted
//   if_valid, if_instr, if_pc   FIFO head towards IF/ID (combinational from head)
//
// Optional: define FETCH_PERF_EN to add the saturating perf_stall_cycles,
// perf_flush_count and perf_drop_count outputs.
module if_fetch_unit #(
  parameter int              XLEN      = 64,
  parameter int              BUF_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flush_count,
  output logic [31:0]     perf_drop_count
`endif
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  // PC of the next response that will be kept; responses are in order and every
  // pre-redirect response is dropped, so kept responses are sequential from here.
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;

  logic [31:0]     instr_mem [BUF_DEPTH];
  logic [XLEN-1:0] pc_mem    [BUF_DEPTH];

  logic            req_valid;
  logic            acc;
  logic            push;
  logic            pop;
  logic [CW:0]     occ;

  always_comb begin
    // Outstanding requests plus buffered words may never exceed the FIFO depth,
    // which is what makes FIFO overflow impossible.
    occ       = {1'b0, out_q} + {1'b0, cnt_q};
    req_valid = (state_q == S_FETCH) && !flush && (occ < (CW+1)'(BUF_DEPTH));
    acc       = req_valid && imem_req_ready;
    pop       = (cnt_q != '0) && !stall && !flush;
    push      = imem_rsp_valid && (drop_q == '0) && !flush;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q + CW'(acc) - CW'(imem_rsp_valid);
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;

    if (flush) begin
      // Everything still outstanding after this cycle belongs to the old path.
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      drop_d     = out_d;
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
    end else begin
      if (acc) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
        wr_d     = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (flush && (out_d != '0)) state_d = S_DRAIN;
      S_DRAIN: if (drop_d == '0) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  // Payload storage needs no reset; validity is carried by cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_q] <= imem_rsp_data;
      pc_mem[wr_q]    <= rsp_pc_q;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (cnt_q == CW'(BUF_DEPTH))));

  assign imem_req_valid = req_valid;
  assign imem_addr      = fetch_pc_q;
  assign if_valid       = (cnt_q != '0);
  assign if_instr       = if_valid ? instr_mem[rd_q] : NOP;
  assign if_pc          = if_valid ? pc_mem[rd_q] : rsp_pc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;
  logic [31:0] perf_drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      if (stall && if_valid && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush && (perf_flush_q != '1))              perf_flush_q <= perf_flush_q + 32'd1;
      // A response landing in a flush cycle is discarded along with the FIFO.
      if (imem_rsp_valid && ((drop_q != '0) || flush) && (perf_drop_q != '1))
        perf_drop_q <= perf_drop_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
  assign perf_drop_count   = perf_drop_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
`timescale 1ns/1ps
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
  logic [31:0] perf_drop_count;
`endif

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count),
    .perf_drop_count   (perf_drop_count)
`endif
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  int          compared = 0;
  int          mismatched = 0;
  pend_t       pend[$];     // requests accepted by the memory, oldest first
  logic [63:0] m_q[$];      // PCs that must be sitting in the prefetch buffer
  logic [63:0] popped[$];   // PCs handed to IF/ID, in order
  logic [63:0] exp_req = '0;
  logic [63:0] rsp_addr = '0;
  int          stale = 0;   // responses still due for requests made before the last redirect
  int          cyc = 0;
  int          last_due = 0;
  int          acc_cnt = 0;
  int          drop_cnt = 0;
  int          m_stall_cnt = 0;
  int          m_flush_cnt = 0;
  bit          active = 1'b0;

  bit          c_rst = 1'b0;
  bit          c_stall = 1'b0;
  bit          c_flush = 1'b0;
  bit          c_ready = 1'b1;
  logic [63:0] c_redir = '0;
  int          c_lat_min = 1;
  int          c_lat_max = 1;

  function automatic logic [31:0] memw(input logic [63:0] a);
    return (a[31:0] * 32'h0100_0193) ^ a[63:32] ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory side and control inputs for the cycle that has just begun.
  task automatic drive();
    rst            = c_rst;
    stall          = c_stall;
    flush          = c_flush;
    redirect_pc    = c_redir;
    imem_req_ready = c_ready;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    cyc++;
    if (!c_rst) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      rsp_addr       = pend[0].addr;
      imem_rsp_data  = memw(rsp_addr);
      void'(pend.pop_front());
    end
  endtask

  // Compare outputs against the model, then advance the model across the coming edge.
  task automatic observe();
    int busy;
    int lat;
    int due;
    bit exp_rv;
    if (!rst) begin
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_imem_addr", imem_addr, 64'h0);
      chk("rst_if_instr", if_instr, 64'h13);
      chk("rst_if_pc", if_pc, 64'h0);
`ifdef FETCH_PERF_EN
      chk("rst_perf_stall", perf_stall_cycles, 0);
      chk("rst_perf_flush", perf_flush_count, 0);
      chk("rst_perf_drop", perf_drop_count, 0);
      m_stall_cnt = 0;
      m_flush_cnt = 0;
      drop_cnt    = 0;
`endif
      m_q.delete();
      pend.delete();
      stale    = 0;
      exp_req  = '0;
      active   = 1'b0;
      last_due = 0;
    end else begin
      busy   = pend.size() + (imem_rsp_valid ? 1 : 0) + m_q.size();
      exp_rv = active && (stale == 0) && !flush && (busy < 4);
      chk("req_valid", imem_req_valid, exp_rv);
      if (imem_req_valid) chk("imem_addr", imem_addr, exp_req);
      chk("if_valid", if_valid, m_q.size() != 0);
      if (if_valid && m_q.size() != 0) begin
        chk("if_pc", if_pc, m_q[0]);
        chk("if_instr", if_instr, memw(m_q[0]));
      end
`ifdef FETCH_PERF_EN
      chk("perf_stall", perf_stall_cycles, m_stall_cnt);
      chk("perf_flush", perf_flush_count, m_flush_cnt);
      chk("perf_drop", perf_drop_count, drop_cnt);
      if (stall && m_q.size() != 0) m_stall_cnt++;
      if (flush) m_flush_cnt++;
`endif
      active = 1'b1;
      if (flush) begin
        m_q.delete();
        exp_req = redirect_pc;
        stale   = pend.size();
        if (imem_rsp_valid) drop_cnt++;
      end else begin
        if (!stall && m_q.size() != 0) popped.push_back(m_q.pop_front());
        if (imem_rsp_valid) begin
          if (stale > 0) begin
            stale--;
            drop_cnt++;
          end else begin
            m_q.push_back(rsp_addr);
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          acc_cnt++;
          lat = $urandom_range(c_lat_max, c_lat_min);
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back('{addr: imem_addr, due: due});
          exp_req = exp_req + 64'd4;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    observe();
  endtask

  initial begin
    int a0;
    int d0;
    int n;
    @(negedge clk);
    observe();
    repeat (3) step();

    // Release: one IDLE cycle without a request, then the first request at RESET_PC.
    c_rst = 1'b1;
    step();
    chk("idle_no_req", imem_req_valid, 0);
    chk("idle_if_valid", if_valid, 0);
    step();
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_addr, 64'h0);

    // Latency 1, always ready: first word visible two cycles after acceptance, then back-to-back.
    step();
    chk("lat1_not_yet_valid", if_valid, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stream_valid", if_valid, 1);
      chk("stream_pc", if_pc, 64'(4 * k));
    end

    // Redirect, then stall 10 cycles: exactly BUF_DEPTH requests, head frozen.
    c_flush = 1'b1;
    c_redir = 64'h200;
    step();
    c_flush = 1'b0;
    c_stall = 1'b1;
    a0 = acc_cnt;
    step();
    chk("flush_empties", if_valid, 0);
    repeat (9) step();
    chk("stall_req_count", acc_cnt - a0, 4);
    chk("stall_head_valid", if_valid, 1);
    chk("stall_head_pc", if_pc, 64'h200);
    c_stall = 1'b0;
    popped.delete();
    repeat (6) step();
    chk("drain_count_ok", popped.size() >= 4, 1);
    for (int k = 0; k < 4 && k < popped.size(); k++) chk("drain_order", popped[k], 64'h200 + 64'(4 * k));

    // Latency 3: redirect with two requests in flight; both responses must be discarded.
    c_lat_min = 3;
    c_lat_max = 3;
    c_flush = 1'b1;
    c_redir = 64'h300;
    step();
    c_flush = 1'b0;
    n = 0;
    while (!(pend.size() == 2 && stale == 0) && n < 40) begin
      step();
      n++;
    end
    chk("two_outstanding_reached", n < 40, 1);
    d0 = drop_cnt;
    c_flush = 1'b1;
    c_redir = 64'h100;
    step();
    c_flush = 1'b0;
    step();
    chk("drain_no_req", imem_req_valid, 0);
    n = 0;
    while (!if_valid && n < 30) begin
      step();
      n++;
    end
    chk("redirect_valid_in_time", n < 30, 1);
    chk("drain_dropped", drop_cnt - d0, 2);
    chk("redirect_pc_first", if_pc, 64'h100);

    // flush and stall together: flush wins.
    c_lat_min = 1;
    c_lat_max = 1;
    c_stall = 1'b1;
    repeat (8) step();
    chk("prefill_valid", if_valid, 1);
    c_flush = 1'b1;
    c_redir = 64'h400;
    step();
    c_flush = 1'b0;
    step();
    chk("flush_over_stall", if_valid, 0);
    c_stall = 1'b0;
    popped.delete();
    n = 0;
    while (popped.size() == 0 && n < 30) begin
      step();
      n++;
    end
    chk("after_flush_stall_pc", (popped.size() > 0) ? popped[0] : 64'hDEAD, 64'h400);

    // PC wraps modulo 2^64.
    c_flush = 1'b1;
    c_redir = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    c_flush = 1'b0;
    popped.delete();
    n = 0;
    while (popped.size() < 3 && n < 40) begin
      step();
      n++;
    end
    chk("wrap_count_ok", popped.size() >= 3, 1);
    if (popped.size() >= 3) begin
      chk("wrap_pc0", popped[0], 64'hFFFF_FFFF_FFFF_FFF8);
      chk("wrap_pc1", popped[1], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_pc2", popped[2], 64'h0);
    end

    // Randomized traffic with an asynchronous reset in the middle.
    c_lat_min = 1;
    c_lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      c_rst   = !(i >= 1500 && i < 1502);
      c_stall = ($urandom % 10) < 3;
      c_flush = ($urandom % 25) == 0;
      c_redir = {$urandom, $urandom} & ~64'h3;
      c_ready = ($urandom % 10) < 7;
      step();
    end

    c_stall = 1'b0;
    c_flush = 1'b0;
    c_ready = 1'b1;
    popped.delete();
    repeat (20) step();
    chk("liveness", popped.size() > 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
